// File: rtl/fec_stats_pkg.sv
// fec_stats_pkg: shared FSM state type and sizing helper for the stats collector
package fec_stats_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/stats_accum.sv
// stats_accum: one total counter with increment and clear; clamps instead of wrapping when STATS_SATURATE_EN is defined
module stats_accum #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] inc_i,
    output logic [CNT_W-1:0] total_o
);

    logic [CNT_W-1:0] total_q, total_d;

`ifdef STATS_SATURATE_EN
    logic [CNT_W:0] sum;
    assign sum = {1'b0, total_q} + {1'b0, inc_i};
    // a carry out means the true total no longer fits, so pin it at all ones
    always_comb total_d = clear_i ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    // plain modulo-2^CNT_W accumulation
    always_comb total_d = clear_i ? '0 : total_q + inc_i;
`endif

    // total register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) total_q <= '0;
        else       total_q <= total_d;

    assign total_o = total_q;

endmodule

// File: rtl/parallel_stats_collector.sv
// parallel_stats_collector: two-stage FEC error statistics over N_LANES frames per cycle; define STATS_SATURATE_EN for clamping totals
module parallel_stats_collector
    import fec_stats_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int FRAME_BITS = 5440,
    parameter int ERR_W      = 13,
    parameter int CNT_W      = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     clear,
    input  logic [CNT_W-1:0]         target_frame_errors,
    input  logic [N_LANES-1:0]       frame_valid,
    input  logic [N_LANES*ERR_W-1:0] frame_err_pre,
    input  logic [N_LANES*ERR_W-1:0] frame_err_post,
    output logic [CNT_W-1:0]         total_bits,
    output logic [CNT_W-1:0]         total_bit_errors_pre,
    output logic [CNT_W-1:0]         total_bit_errors_post,
    output logic [CNT_W-1:0]         total_frames,
    output logic [CNT_W-1:0]         total_frame_errors,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int SUM_W  = ERR_W + clog2(N_LANES);
    localparam int LCNT_W = clog2(N_LANES + 1);

    logic [1:0]          rst_sync_q;
    logic                rst_n;
    state_e              state_q, state_d;
    logic [N_LANES-1:0]  acc;
    logic [LCNT_W-1:0]   cnt_q, cnt_d, ferr_q, ferr_d;
    logic [SUM_W-1:0]    pre_q, pre_d, post_q, post_d;

    // reset asserts immediately but releases only on a clock edge
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rst_sync_q <= '0;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};

    assign rst_n = rst_sync_q[1];
    assign acc   = (state_q == STATE_RUN && !clear) ? frame_valid : '0;

    // per-cycle sums over the accepted lanes
    always_comb begin
        cnt_d  = '0;
        ferr_d = '0;
        pre_d  = '0;
        post_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            cnt_d  = cnt_d + LCNT_W'(acc[i]);
            ferr_d = ferr_d + LCNT_W'(acc[i] && frame_err_post[i*ERR_W +: ERR_W] != '0);
            pre_d  = pre_d + (acc[i] ? SUM_W'(frame_err_pre[i*ERR_W +: ERR_W]) : '0);
            post_d = post_d + (acc[i] ? SUM_W'(frame_err_post[i*ERR_W +: ERR_W]) : '0);
        end
    end

    // stage-1 register; clear zeroes it because no lane is accepted under clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q  <= '0;
            ferr_q <= '0;
            pre_q  <= '0;
            post_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ferr_q <= ferr_d;
            pre_q  <= pre_d;
            post_q <= post_d;
        end

    stats_accum #(.CNT_W(CNT_W)) u_bits (
        .clk(clk), .rstn(rst_n), .clear_i(clear),
        .inc_i(CNT_W'(cnt_q) * CNT_W'(FRAME_BITS)), .total_o(total_bits)
    );

    stats_accum #(.CNT_W(CNT_W)) u_pre (
        .clk(clk), .rstn(rst_n), .clear_i(clear),
        .inc_i(CNT_W'(pre_q)), .total_o(total_bit_errors_pre)
    );

    stats_accum #(.CNT_W(CNT_W)) u_post (
        .clk(clk), .rstn(rst_n), .clear_i(clear),
        .inc_i(CNT_W'(post_q)), .total_o(total_bit_errors_post)
    );

    stats_accum #(.CNT_W(CNT_W)) u_frames (
        .clk(clk), .rstn(rst_n), .clear_i(clear),
        .inc_i(CNT_W'(cnt_q)), .total_o(total_frames)
    );

    stats_accum #(.CNT_W(CNT_W)) u_ferr (
        .clk(clk), .rstn(rst_n), .clear_i(clear),
        .inc_i(CNT_W'(ferr_q)), .total_o(total_frame_errors)
    );

    // next state: clear dominates, DONE is left only through clear
    always_comb begin
        state_d = clear ? STATE_IDLE
                : state_q == STATE_IDLE ? (en ? STATE_RUN : STATE_IDLE)
                : state_q == STATE_RUN  ? (!en ? STATE_IDLE
                                          : (target_frame_errors != '0 && total_frame_errors >= target_frame_errors)
                                            ? STATE_DONE : STATE_RUN)
                : state_q == STATE_DONE ? STATE_DONE
                : STATE_IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= STATE_IDLE;
        else        state_q <= state_d;

    assign state = state_q;
    assign done  = state_q == STATE_DONE;

endmodule
